cdc_sync_filt: RTL and testbench

- Multi-channel level synchroniser with a per-channel glitch filter and edge-pulse outputs. Successor to the plain N-stage data synchroniser.
- Brings CH independent asynchronous single-bit levels (IRQs, status pins, handshake levels) into the clk domain.
- Rejects pulses shorter than FILT cycles and emits one-cycle rise/fall/any-change strobes for downstream control logic.
- Sits at the destination-domain boundary; the only clock is the destination clock.

---
 rtl/cdc_sync_filt.sv | 129 ++++++++++++
 tb/tb_cdc_sync_filt.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_sync_filt.sv
// Multi-channel level synchroniser with per-channel glitch filter and edge strobes.
// din crosses via an N-flop chain; dout follows only after FILT stable cycles.
module cdc_sync_filt #(
  parameter int              CH      = 4,
  parameter int              N       = 2,
  parameter int              FILT    = 4,
  parameter logic [CH-1:0]   RST_VAL = {CH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_chg
);

  // FILT=0 degenerates to a one-sample filter, identical to FILT=1.
  localparam int             FMAX     = (FILT < 1) ? 1 : FILT;
  localparam int             CW       = ($clog2(FILT + 1) < 1) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FMAX - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

  logic [CH-1:0] sync_r [N];
  logic [CH-1:0] s_s;
  logic [CW-1:0] cnt_r     [CH];
  logic [CW-1:0] cnt_nxt_s [CH];
  logic [CH-1:0] dout_r;
  logic [CH-1:0] rise_r;
  logic [CH-1:0] fall_r;
  logic          any_chg_r;
  logic [CH-1:0] dout_nxt_s;
  logic [CH-1:0] rise_nxt_s;
  logic [CH-1:0] fall_nxt_s;

  assign s_s = sync_r[N-1];

  // Synchroniser shift chain; the only logic that ever sees raw din.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        sync_r[i] <= RST_VAL;
      end
    end else begin
      sync_r[0] <= din;
      for (int i = 1; i < N; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Per-channel stability counter; a difference that vanishes early clears the count.
  always_comb begin
    dout_nxt_s = dout_r;
    rise_nxt_s = {CH{1'b0}};
    fall_nxt_s = {CH{1'b0}};
    for (int c = 0; c < CH; c++) begin
      cnt_nxt_s[c] = cnt_r[c];
      if (s_s[c] == dout_r[c]) begin
        cnt_nxt_s[c] = CNT_ZERO;
      end else if (cnt_r[c] == CNT_LAST) begin
        cnt_nxt_s[c]  = CNT_ZERO;
        dout_nxt_s[c] = s_s[c];
        rise_nxt_s[c] = s_s[c];
        fall_nxt_s[c] = ~s_s[c];
      end else begin
        cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
      end
    end
  end

  // Output registers: strobes are loaded at the same edge dout takes its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r    <= RST_VAL;
      rise_r    <= {CH{1'b0}};
      fall_r    <= {CH{1'b0}};
      any_chg_r <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        cnt_r[c] <= CNT_ZERO;
      end
    end else begin
      dout_r    <= dout_nxt_s;
      rise_r    <= rise_nxt_s;
      fall_r    <= fall_nxt_s;
      any_chg_r <= |(rise_nxt_s | fall_nxt_s);
      for (int c = 0; c < CH; c++) begin
        cnt_r[c] <= cnt_nxt_s[c];
      end
    end
  end

  assign dout    = dout_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign any_chg = any_chg_r;

  cdc_sync_filt_chk #(.CH(CH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .rise    (rise_r),
    .fall    (fall_r),
    .any_chg (any_chg_r)
  );

endmodule

// Invariants of the strobe outputs.
module cdc_sync_filt_chk #(
  parameter int CH = 4
) (
  input logic          clk,
  input logic          rst,
  input logic [CH-1:0] rise,
  input logic [CH-1:0] fall,
  input logic          any_chg
);

  a_excl: assert property (@(posedge clk) disable iff (rst)
    (rise & fall) == {CH{1'b0}});

  a_any: assert property (@(posedge clk) disable iff (rst)
    any_chg == |(rise | fall));

  a_rst_quiet: assert property (@(posedge clk)
    rst |=> (rise == {CH{1'b0}} && fall == {CH{1'b0}} && !any_chg));

endmodule

// File: tb/tb_cdc_sync_filt.sv
// Bench for cdc_sync_filt: default instance (N=2, FILT=4) and bypass instance (N=3, FILT=0).
module tb_cdc_sync_filt;

  localparam int MAXT = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din, din2;
  logic [3:0] dout, rise, fall, dout2, rise2, fall2;
  logic       any_chg, any_chg2;

  always #5 clk = ~clk;

  cdc_sync_filt u_dut (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .any_chg(any_chg)
  );

  cdc_sync_filt #(.N(3), .FILT(0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2),
    .dout(dout2), .rise(rise2), .fall(fall2), .any_chg(any_chg2)
  );

  wire [12:0] obs0 = {dout, rise, fall, any_chg};
  wire [12:0] obs1 = {dout2, rise2, fall2, any_chg2};

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;

  // Reference model: raw histories of sampled din/rst per edge.
  logic [3:0] dh [2][MAXT];
  bit         rh [MAXT];
  logic [3:0] m_dout [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  int         m_last [2][4];

  // Value held in the last sync stage right after edge tt.
  function automatic logic [3:0] s_after(input int d, input int tt);
    int nn;
    nn = (d == 0) ? 2 : 3;
    if (tt < 0) return 4'h0;
    for (int j = 0; j < nn; j++)
      if (tt - j >= 0 && rh[tt - j]) return 4'h0;
    if (tt - nn + 1 < 0) return 4'h0;
    return dh[d][tt - nn + 1];
  endfunction

  // dout flips when the last FMAX register samples all differ from it.
  task automatic model_edge(input int d, input logic [3:0] dv);
    int fm;
    bit ok;
    logic [3:0] s;
    fm = (d == 0) ? 4 : 1;
    dh[d][t] = dv;
    m_rise[d] = 4'h0;
    m_fall[d] = 4'h0;
    if (rh[t]) begin
      m_dout[d] = 4'h0;
      for (int c = 0; c < 4; c++) m_last[d][c] = t;
    end else begin
      for (int c = 0; c < 4; c++) begin
        ok = (t - m_last[d][c] >= fm);
        for (int j = 0; j < fm; j++) begin
          s = s_after(d, t - 1 - j);
          if (s[c] == m_dout[d][c]) ok = 1'b0;
        end
        if (ok) begin
          m_dout[d][c] = ~m_dout[d][c];
          if (m_dout[d][c]) m_rise[d][c] = 1'b1;
          else              m_fall[d][c] = 1'b1;
          m_last[d][c] = t;
        end
      end
    end
  endtask

  function automatic logic [12:0] ev(input int d);
    return {m_dout[d], m_rise[d], m_fall[d], |(m_rise[d] | m_fall[d])};
  endfunction

  task automatic step();
    @(posedge clk);
    t++;
    if (t >= MAXT) begin
      $display("FAIL cycle_budget t=%0d limit=%0d", t, MAXT);
      $fatal(1, "cycle budget exhausted");
    end
    rh[t] = rst;
    model_edge(0, din);
    model_edge(1, din2);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    int k, re, n_any;
    logic [3:0] r_at;
    rst = 1'b1; din = 4'hF; din2 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (obs0 !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_hold t=%0d got=%h want=%h", t, obs0, 13'h0);
      end
    end
    rst = 1'b0;
    k = t + 1; re = -1; n_any = 0; r_at = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (obs0 !== ev(0)) begin
        n_fail++;
        $display("FAIL reset_release t=%0d got=%h want=%h", t, obs0, ev(0));
      end
      if (rise !== 4'h0 && re < 0) begin re = t; r_at = rise; end
      if (any_chg) n_any++;
    end
    n_chk++;
    if (re !== k + 5) begin
      n_fail++;
      $display("FAIL reset_latency got=%0d want=%0d", re, k + 5);
    end
    n_chk++;
    if (r_at !== 4'hF || n_any !== 1) begin
      n_fail++;
      $display("FAIL reset_strobe rise=%h any_cnt=%0d want rise=f any_cnt=1", r_at, n_any);
    end
  endtask

  task automatic test_step();
    int k, re, fe;
    din = 4'h0; din2 = 4'h0;
    settle(8);
    din[0] = 1'b1; k = t + 1; re = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (obs0 !== ev(0)) begin
        n_fail++;
        $display("FAIL step_up t=%0d got=%h want=%h", t, obs0, ev(0));
      end
      if (rise === 4'b0001 && any_chg && re < 0) re = t;
    end
    n_chk++;
    if (re !== k + 5) begin
      n_fail++;
      $display("FAIL step_rise_lat got=%0d want=%0d", re, k + 5);
    end
    din[0] = 1'b0; k = t + 1; fe = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (obs0 !== ev(0)) begin
        n_fail++;
        $display("FAIL step_down t=%0d got=%h want=%h", t, obs0, ev(0));
      end
      if (fall === 4'b0001 && fe < 0) fe = t;
    end
    n_chk++;
    if (fe !== k + 5) begin
      n_fail++;
      $display("FAIL step_fall_lat got=%0d want=%0d", fe, k + 5);
    end
  endtask

  task automatic test_glitch();
    int w, nr;
    for (int r = 0; r < 6; r++) begin
      case (r)
        0:       w = 3;
        1:       w = 4;
        2, 3:    w = $urandom_range(1, 3);
        default: w = $urandom_range(4, 7);
      endcase
      din = 4'h0;
      settle(8);
      din[1] = 1'b1; nr = 0;
      for (int i = 0; i < w; i++) begin
        step();
        n_chk++;
        if (obs0 !== ev(0)) begin
          n_fail++;
          $display("FAIL glitch_hi w=%0d t=%0d got=%h want=%h", w, t, obs0, ev(0));
        end
        if (rise[1]) nr++;
      end
      din[1] = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        n_chk++;
        if (obs0 !== ev(0)) begin
          n_fail++;
          $display("FAIL glitch_lo w=%0d t=%0d got=%h want=%h", w, t, obs0, ev(0));
        end
        if (rise[1]) nr++;
      end
      n_chk++;
      if (nr !== ((w >= 4) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL glitch_count w=%0d got=%0d want=%0d", w, nr, (w >= 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_simul();
    int k, e, n_any;
    logic [3:0] r_at, f_at;
    din = 4'b1000;
    settle(8);
    din = 4'b0100; k = t + 1; e = -1; n_any = 0; r_at = 4'h0; f_at = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (obs0 !== ev(0)) begin
        n_fail++;
        $display("FAIL simul t=%0d got=%h want=%h", t, obs0, ev(0));
      end
      if (any_chg) begin n_any++; e = t; r_at = rise; f_at = fall; end
    end
    n_chk++;
    if (e !== k + 5 || n_any !== 1 || r_at !== 4'b0100 || f_at !== 4'b1000) begin
      n_fail++;
      $display("FAIL simul_strobe edge=%0d any_cnt=%0d rise=%b fall=%b want edge=%0d any_cnt=1 rise=0100 fall=1000",
               e, n_any, r_at, f_at, k + 5);
    end
  endtask

  task automatic test_reset_mid();
    int kk, re, n_str;
    din = 4'h0;
    settle(8);
    din[0] = 1'b1; n_str = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (any_chg) n_str++;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++;
      if (obs0 !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_mid_hold t=%0d got=%h want=%h", t, obs0, 13'h0);
      end
    end
    rst = 1'b0; kk = t + 1; re = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (obs0 !== ev(0)) begin
        n_fail++;
        $display("FAIL reset_mid_run t=%0d got=%h want=%h", t, obs0, ev(0));
      end
      if (any_chg && re < 0) re = t;
    end
    n_chk++;
    if (re !== kk + 5 || n_str !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_lat got=%0d early=%0d want=%0d early=0", re, n_str, kk + 5);
    end
  endtask

  task automatic test_bypass();
    int k, re, fe, hi;
    din2 = 4'h0;
    settle(6);
    din2[0] = 1'b1; k = t + 1;
    step();
    din2[0] = 1'b0; re = -1; fe = -1; hi = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if (obs1 !== ev(1)) begin
        n_fail++;
        $display("FAIL bypass_pulse t=%0d got=%h want=%h", t, obs1, ev(1));
      end
      if (rise2[0]) re = t;
      if (fall2[0]) fe = t;
      if (dout2[0]) hi++;
    end
    n_chk++;
    if (re !== k + 3 || fe !== k + 4 || hi !== 1) begin
      n_fail++;
      $display("FAIL bypass_timing rise=%0d fall=%0d hi=%0d want rise=%0d fall=%0d hi=1",
               re, fe, hi, k + 3, k + 4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) din[c]  = ~din[c];
        if ($urandom_range(0, 3) == 0) din2[c] = ~din2[c];
      end
      rst = ($urandom_range(0, 79) == 0);
      step();
      n_chk++;
      if (obs0 !== ev(0)) begin
        n_fail++;
        $display("FAIL random_a t=%0d got=%h want=%h", t, obs0, ev(0));
      end
      n_chk++;
      if (obs1 !== ev(1)) begin
        n_fail++;
        $display("FAIL random_b t=%0d got=%h want=%h", t, obs1, ev(1));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_dout[d] = 4'h0; m_rise[d] = 4'h0; m_fall[d] = 4'h0;
      for (int c = 0; c < 4; c++) m_last[d][c] = 0;
    end
    rst = 1'b1; din = 4'hF; din2 = 4'hF;
    test_reset();
    test_step();
    test_glitch();
    test_simul();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
